// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared encodings for the data-memory responder: access-size
//                codes, responder FSM states and the data word width.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam int WORD_W = 32;

    // Access size as presented on the request port
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    // Responder FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_lane_align
//  Description : Combinational byte-lane steering for a 32-bit word RAM.
//                Store path: byte enables plus lane-replicated write data.
//                Load path : lane select followed by sign/zero extension.
//  Revision    : 1.0 - initial release
//
//  Ports
//    i_addr_lo    in   2   byte offset within the word (addr[1:0])
//    i_size       in   2   access size code (SZ_BYTE/SZ_HALF/SZ_WORD)
//    i_wdata      in   32  right-aligned store data
//    i_rword      in   32  RAM word read for a load
//    i_unsigned   in   1   1 = zero-extend, 0 = sign-extend loads
//    o_be         out  4   per-lane write enables (0 for illegal size)
//    o_wdata_sh   out  32  store data placed on its lane(s)
//    o_rdata_ext  out  32  extended load data
// ============================================================================
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]        i_addr_lo,
    input  logic [1:0]        i_size,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [WORD_W-1:0] i_rword,
    input  logic              i_unsigned,
    output logic [3:0]        o_be,
    output logic [WORD_W-1:0] o_wdata_sh,
    output logic [WORD_W-1:0] o_rdata_ext
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Store data is replicated across all lanes; the byte enables pick
    // which copy lands in the RAM, so no barrel shifter is needed.
    always_comb begin
        o_be       = 4'b0000;
        o_wdata_sh = '0;
        case (i_size)
            SZ_BYTE: begin
                o_be       = 4'b0001 << i_addr_lo;
                o_wdata_sh = {4{i_wdata[7:0]}};
            end
            SZ_HALF: begin
                o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata_sh = {2{i_wdata[15:0]}};
            end
            SZ_WORD: begin
                o_be       = 4'b1111;
                o_wdata_sh = i_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte = 8'h00;
        case (i_addr_lo)
            2'd0:    w_byte = i_rword[7:0];
            2'd1:    w_byte = i_rword[15:8];
            2'd2:    w_byte = i_rword[23:16];
            default: w_byte = i_rword[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

        o_rdata_ext = '0;
        case (i_size)
            SZ_BYTE: o_rdata_ext = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            SZ_HALF: o_rdata_ext = {{16{~i_unsigned & w_half[15]}}, w_half};
            SZ_WORD: o_rdata_ext = i_rword;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Memory end of the core load/store port. Word-organised RAM
//                with byte-lane stores, sign/zero-extended loads and error
//                reporting for misaligned, out-of-range and illegal-size
//                accesses. One transaction in flight.
//  Revision    : 1.0 - initial release
//
//  Build option
//    DMEM_WAIT_EN  when defined, a WAIT state adds WAIT_CYCLES of response
//                  latency (WAIT_CYCLES=0 behaves as undefined).
//
//  Parameters
//    DEPTH_WORDS   RAM depth in 32-bit words (power of two, >= 2)
//    BASE_ADDR     byte address of word 0
//    WAIT_CYCLES   extra response latency (DMEM_WAIT_EN only)
//
//  Ports
//    i_clk           in   1   clock, rising edge
//    i_rst_n         in   1   asynchronous active-low reset
//    i_req_valid     in   1   request present
//    o_req_ready     out  1   request can be accepted (IDLE only)
//    i_req_we        in   1   1 = store, 0 = load
//    i_req_addr      in   32  byte address
//    i_req_size      in   2   00 byte, 01 half, 10 word, 11 illegal
//    i_req_unsigned  in   1   loads: 1 zero-extend, 0 sign-extend
//    i_req_wdata     in   32  right-aligned store data
//    o_rsp_valid     out  1   response present
//    i_rsp_ready     in   1   core accepts response
//    o_rsp_rdata     out  32  extended load data; 0 for stores / errors
//    o_rsp_err       out  1   access faulted, no side effect
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [31:0]       i_req_addr,
    input  logic [1:0]        i_req_size,
    input  logic              i_req_unsigned,
    input  logic [WORD_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [WORD_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err
);

    localparam int          IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [32:0] c_span = 33'(DEPTH_WORDS) << 2;

    dmem_state_e       r_state;
    dmem_state_e       w_state_nxt;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [WORD_W-1:0] r_rsp_rdata;
    logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

    logic              w_accept;
    logic              w_issue;      // response is formed (and store committed) this edge
    logic              w_commit;

    // Request fields feeding the access logic: live inputs when the response
    // is formed straight out of IDLE, captured copies when leaving WAIT.
    logic              w_src_we;
    logic [31:0]       w_src_addr;
    logic [1:0]        w_src_size;
    logic              w_src_uns;
    logic [WORD_W-1:0] w_src_wdata;

    logic [31:0]       w_offset;
    logic              w_oor;
    logic              w_misalign;
    logic              w_err;
    logic [IDX_W-1:0]  w_idx;
    logic [WORD_W-1:0] w_rword;
    logic [3:0]        w_be;
    logic [WORD_W-1:0] w_wdata_sh;
    logic [WORD_W-1:0] w_rdata_ext;

    assign w_accept = i_req_valid & r_req_ready;

`ifdef DMEM_WAIT_EN
    localparam int               CNT_W      = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam bit               c_use_wait = (WAIT_CYCLES > 0);

    logic [CNT_W-1:0]  r_wait_cnt;
    logic              r_cap_we;
    logic [31:0]       r_cap_addr;
    logic [1:0]        r_cap_size;
    logic              r_cap_uns;
    logic [WORD_W-1:0] r_cap_wdata;
    logic              w_wait_done;

    assign w_wait_done = (r_state == ST_WAIT) && (r_wait_cnt == c_cnt_last);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cap_we    <= 1'b0;
            r_cap_addr  <= '0;
            r_cap_size  <= '0;
            r_cap_uns   <= 1'b0;
            r_cap_wdata <= '0;
        end else if (w_accept) begin
            r_cap_we    <= i_req_we;
            r_cap_addr  <= i_req_addr;
            r_cap_size  <= i_req_size;
            r_cap_uns   <= i_req_unsigned;
            r_cap_wdata <= i_req_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wait_cnt <= '0;
        end else if ((r_state == ST_WAIT) && !w_wait_done) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end else begin
            r_wait_cnt <= '0;
        end
    end

    always_comb begin
        if (r_state == ST_WAIT) begin
            w_src_we    = r_cap_we;
            w_src_addr  = r_cap_addr;
            w_src_size  = r_cap_size;
            w_src_uns   = r_cap_uns;
            w_src_wdata = r_cap_wdata;
        end else begin
            w_src_we    = i_req_we;
            w_src_addr  = i_req_addr;
            w_src_size  = i_req_size;
            w_src_uns   = i_req_unsigned;
            w_src_wdata = i_req_wdata;
        end
    end
`else
    assign w_src_we    = i_req_we;
    assign w_src_addr  = i_req_addr;
    assign w_src_size  = i_req_size;
    assign w_src_uns   = i_req_unsigned;
    assign w_src_wdata = i_req_wdata;
`endif

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
`ifdef DMEM_WAIT_EN
                    if (c_use_wait) begin
                        w_state_nxt = ST_WAIT;
                    end else begin
                        w_state_nxt = ST_RESP;
                        w_issue     = 1'b1;
                    end
`else
                    w_state_nxt = ST_RESP;
                    w_issue     = 1'b1;
`endif
                end
            end
            ST_WAIT: begin
`ifdef DMEM_WAIT_EN
                if (w_wait_done) begin
                    w_state_nxt = ST_RESP;
                    w_issue     = 1'b1;
                end
`else
                w_state_nxt = ST_IDLE;
`endif
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Error check and addressing
    // ------------------------------------------------------------------
    // Unsigned subtract wraps, so addresses below BASE_ADDR land far above
    // the span and are caught by the same comparison.
    assign w_offset   = w_src_addr - BASE_ADDR;
    assign w_oor      = {1'b0, w_offset} >= c_span;
    assign w_misalign = ((w_src_size == SZ_HALF) && w_src_addr[0]) ||
                        ((w_src_size == SZ_WORD) && (w_src_addr[1:0] != 2'b00));
    assign w_err      = (w_src_size == SZ_ILL) || w_misalign || w_oor;
    assign w_idx      = w_offset[IDX_W+1:2];
    assign w_rword    = r_mem[w_idx];
    assign w_commit   = w_issue && w_src_we && !w_err;

    dmem_lane_align u_lane_align (
        .i_addr_lo   (w_src_addr[1:0]),
        .i_size      (w_src_size),
        .i_wdata     (w_src_wdata),
        .i_rword     (w_rword),
        .i_unsigned  (w_src_uns),
        .o_be        (w_be),
        .o_wdata_sh  (w_wdata_sh),
        .o_rdata_ext (w_rdata_ext)
    );

    // RAM contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State, handshake and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= (w_state_nxt == ST_IDLE);
            if (w_issue) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= w_err;
                r_rsp_rdata <= (w_src_we || w_err) ? '0 : w_rdata_ext;
            end else if ((r_state == ST_RESP) && i_rsp_ready) begin
                r_rsp_valid <= 1'b0;
                r_rsp_rdata <= '0;
                r_rsp_err   <= 1'b0;
            end
        end
    end

    assign o_req_ready = r_req_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Self-checking bench for dmem_responder. Directed requests
//                push hand-computed responses into a queue; a monitor pops
//                and compares on every response handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int unsigned WAIT_CYCLES = 3;
`ifdef DMEM_WAIT_EN
    localparam int EXP_LAT = 1 + WAIT_CYCLES;
`else
    localparam int EXP_LAT = 1;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_we = 1'b0;
    logic [31:0] i_req_addr = '0;
    logic [1:0]  i_req_size = '0;
    logic        i_req_unsigned = 1'b0;
    logic [31:0] i_req_wdata = '0;
    logic        o_rsp_valid;
    logic        i_rsp_ready = 1'b1;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;

    dmem_responder #(
        .DEPTH_WORDS (1024),
        .BASE_ADDR   (32'h0000_0000),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_we       (i_req_we),
        .i_req_addr     (i_req_addr),
        .i_req_size     (i_req_size),
        .i_req_unsigned (i_req_unsigned),
        .i_req_wdata    (i_req_wdata),
        .o_rsp_valid    (o_rsp_valid),
        .i_rsp_ready    (i_rsp_ready),
        .o_rsp_rdata    (o_rsp_rdata),
        .o_rsp_err      (o_rsp_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: one comparison set per response handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (i_rst_n && o_rsp_valid && i_rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_rsp: got rdata 0x%08h err %0b, expected no response",
                             o_rsp_rdata, o_rsp_err);
                end else begin
                    e = exp_q.pop_front();
                    check32({e.name, "_rdata"}, o_rsp_rdata, e.rdata);
                    check32({e.name, "_err"}, 32'(o_rsp_err), 32'(e.err));
                end
            end
        end
    end

    // Present one request; returns #1 after the response appears (wait_valid)
    // or #1 after the accept edge.
    task automatic do_req(input string name, input logic we, input logic [31:0] addr,
                          input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input bit push, input bit wait_valid);
        int   n;
        exp_t e;
        n = 0;
        while (!o_req_ready && n < 50) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        if (!o_req_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_ready_timeout: got o_req_ready 0, expected 1 within 50 cycles", name);
            return;
        end
        i_req_valid    = 1'b1;
        i_req_we       = we;
        i_req_addr     = addr;
        i_req_size     = size;
        i_req_unsigned = uns;
        i_req_wdata    = wdata;
        @(posedge i_clk);
        if (push) begin
            e.name  = name;
            e.rdata = exp_rdata;
            e.err   = exp_err;
            exp_q.push_back(e);
        end
        #1;
        i_req_valid = 1'b0;
        if (wait_valid) begin
            n = 1;
            while (!o_rsp_valid && n < 40) begin
                @(posedge i_clk);
                #1;
                n++;
            end
            check32({name, "_latency"}, 32'(n), 32'(EXP_LAT));
        end
    endtask

    // Full transaction with i_rsp_ready high: response consumed on next edge
    task automatic txn(input string name, input logic we, input logic [31:0] addr,
                       input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
        do_req(name, we, addr, size, uns, wdata, exp_rdata, exp_err, 1'b1, 1'b1);
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge i_clk);
        #1;
        check32("reset_req_ready", 32'(o_req_ready), 32'd0);
        check32("reset_rsp_valid", 32'(o_rsp_valid), 32'd0);
        check32("reset_rsp_rdata", o_rsp_rdata, 32'd0);
        check32("reset_rsp_err",   32'(o_rsp_err), 32'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check32("ready_before_edge", 32'(o_req_ready), 32'd0);
        @(posedge i_clk);
        #1;
        check32("ready_after_edge", 32'(o_req_ready), 32'd1);

        // Basic word store / load
        txn("sw_0",   1'b1, 32'h0, SZ_WORD, 1'b0, 32'd1337, 32'h0, 1'b0);
        txn("lw_0",   1'b0, 32'h0, SZ_WORD, 1'b0, 32'h0, 32'h0000_0539, 1'b0);
        check32("ready_after_rsp", 32'(o_req_ready), 32'd1);
        check32("valid_after_rsp", 32'(o_rsp_valid), 32'd0);

        // Byte lanes and extension
        txn("sw_4",   1'b1, 32'h4, SZ_WORD, 1'b0, 32'h1122_3344, 32'h0, 1'b0);
        txn("sb_5",   1'b1, 32'h5, SZ_BYTE, 1'b0, 32'h0000_00AB, 32'h0, 1'b0);
        txn("lw_4",   1'b0, 32'h4, SZ_WORD, 1'b0, 32'h0, 32'h1122_AB44, 1'b0);
        txn("lb_5",   1'b0, 32'h5, SZ_BYTE, 1'b0, 32'h0, 32'hFFFF_FFAB, 1'b0);
        txn("lbu_5",  1'b0, 32'h5, SZ_BYTE, 1'b1, 32'h0, 32'h0000_00AB, 1'b0);
        txn("sh_6",   1'b1, 32'h6, SZ_HALF, 1'b0, 32'h0000_8001, 32'h0, 1'b0);
        txn("lh_6",   1'b0, 32'h6, SZ_HALF, 1'b0, 32'h0, 32'hFFFF_8001, 1'b0);
        txn("lhu_6",  1'b0, 32'h6, SZ_HALF, 1'b1, 32'h0, 32'h0000_8001, 1'b0);
        txn("lw_4b",  1'b0, 32'h4, SZ_WORD, 1'b0, 32'h0, 32'h8001_AB44, 1'b0);

        // Errors: misaligned, out of range, illegal size
        txn("lw_mis2",  1'b0, 32'h2, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b1);
        txn("sh_mis3",  1'b1, 32'h3, SZ_HALF, 1'b0, 32'h0000_FFFF, 32'h0, 1'b1);
        txn("lw_0_chk", 1'b0, 32'h0, SZ_WORD, 1'b0, 32'h0, 32'h0000_0539, 1'b0);
        txn("lw_oor",   1'b0, 32'h1000, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b1);
        txn("lw_wrap",  1'b0, 32'hFFFF_FFFC, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b1);
        txn("st_ill",   1'b1, 32'h0, SZ_ILL, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1);
        txn("lw_0_ill", 1'b0, 32'h0, SZ_WORD, 1'b0, 32'h0, 32'h0000_0539, 1'b0);

        // Last word in range
        txn("sw_top",   1'b1, 32'hFFC, SZ_WORD, 1'b0, 32'hCAFE_F00D, 32'h0, 1'b0);
        txn("lw_top",   1'b0, 32'hFFC, SZ_WORD, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0);
        txn("lb_fff",   1'b0, 32'hFFF, SZ_BYTE, 1'b0, 32'h0, 32'hFFFF_FFCA, 1'b0);
        txn("lhu_ffe",  1'b0, 32'hFFE, SZ_HALF, 1'b1, 32'h0, 32'h0000_CAFE, 1'b0);

        // Backpressure: response held, competing store must not be taken
        i_rsp_ready = 1'b0;
        do_req("bp_lw", 1'b0, 32'h4, SZ_WORD, 1'b0, 32'h0, 32'h8001_AB44, 1'b0, 1'b1, 1'b1);
        i_req_valid = 1'b1;
        i_req_we    = 1'b1;
        i_req_addr  = 32'h0;
        i_req_size  = SZ_WORD;
        i_req_wdata = 32'hFFFF_FFFF;
        for (int c = 0; c < 5; c++) begin
            @(negedge i_clk);
            check32("bp_valid", 32'(o_rsp_valid), 32'd1);
            check32("bp_rdata", o_rsp_rdata, 32'h8001_AB44);
            check32("bp_err",   32'(o_rsp_err), 32'd0);
            check32("bp_ready", 32'(o_req_ready), 32'd0);
        end
        @(posedge i_clk);
        #1;
        i_req_valid = 1'b0;
        i_rsp_ready = 1'b1;
        @(posedge i_clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clk);
            check32("bp_no_extra_rsp", 32'(o_rsp_valid), 32'd0);
        end
        txn("lw_0_bp", 1'b0, 32'h0, SZ_WORD, 1'b0, 32'h0, 32'h0000_0539, 1'b0);

        // Reset in the middle of a store
`ifdef DMEM_WAIT_EN
        txn("sw_8_old", 1'b1, 32'h8, SZ_WORD, 1'b0, 32'h1234_5678, 32'h0, 1'b0);
        do_req("rst_sw", 1'b1, 32'h8, SZ_WORD, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, 1'b0);
        #2;
        i_rst_n = 1'b0;
        #1;
        check32("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        check32("rst_req_ready", 32'(o_req_ready), 32'd0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        txn("lw_8_after_rst", 1'b0, 32'h8, SZ_WORD, 1'b0, 32'h0, 32'h1234_5678, 1'b0);
`else
        i_rsp_ready = 1'b0;
        do_req("rst_sw", 1'b1, 32'h8, SZ_WORD, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, 1'b1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check32("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        check32("rst_req_ready", 32'(o_req_ready), 32'd0);
        check32("rst_rsp_rdata", o_rsp_rdata, 32'd0);
        i_rsp_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        txn("lw_8_after_rst", 1'b0, 32'h8, SZ_WORD, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0);
`endif

        repeat (3) @(posedge i_clk);
        #1;
        check32("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
